// File: rtl/lut_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : lut_arbiter
// Purpose  : Arbitrates one single-port lookup table between NumRx receive-port
//            read requesters and one configuration (CPU) read/write port.
//            One table access is in flight at a time: IDLE -> ACCESS -> RESP.
//            The CPU has priority, except that immediately after a CPU grant
//            any pending rx request wins. Rx ports are served round-robin.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            rx_req/rx_addr            per-port read request and packed address
//            rx_ack/rx_rdata           per-port completion pulse, shared data
//            cpu_req/we/addr/wdata     configuration access request
//            cpu_ack/cpu_rdata         configuration completion pulse and data
//            mem_en/we/addr/wdata      registered table access strobe
//            mem_rdata                 table read data (one cycle after mem_en)
// Revision : 1.0 - initial release
//==============================================================================
module lut_arbiter #(
    parameter int NumRx = 4,
    parameter int Asize = 8,
    parameter int Dsize = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NumRx-1:0]       rx_req,
    input  logic [NumRx*Asize-1:0] rx_addr,
    output logic [NumRx-1:0]       rx_ack,
    output logic [Dsize-1:0]       rx_rdata,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [Asize-1:0]       cpu_addr,
    input  logic [Dsize-1:0]       cpu_wdata,
    output logic                   cpu_ack,
    output logic [Dsize-1:0]       cpu_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [Asize-1:0]       mem_addr,
    output logic [Dsize-1:0]       mem_wdata,
    input  logic [Dsize-1:0]       mem_rdata
);

    localparam int c_IDX_W = (NumRx > 1) ? $clog2(NumRx) : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic               r_grant_cpu;   // current grant belongs to the CPU port
    logic               r_grant_we;    // current grant is a CPU write
    logic [c_IDX_W-1:0] r_grant_idx;   // rx port of the current grant
    logic [c_IDX_W-1:0] r_last_rx;     // last rx port granted (round-robin pointer)
    logic               r_last_cpu;    // previous grant went to the CPU

    logic               r_mem_en;
    logic               r_mem_we;
    logic [Asize-1:0]   r_mem_addr;
    logic [Dsize-1:0]   r_mem_wdata;

    logic [Asize-1:0]   w_addr_arr [NumRx];
    logic [c_IDX_W:0]   w_rr_sum;
    logic [c_IDX_W-1:0] w_rr_idx;
    logic               w_any_rx;
    logic               w_pick_cpu;
    logic               w_start;

    // Unpack the rx address bus into an array indexed by port number.
    generate
        for (genvar g = 0; g < NumRx; g++) begin : g_addr_unpack
            assign w_addr_arr[g] = rx_addr[g*Asize +: Asize];
        end
    endgenerate

    assign w_any_rx   = |rx_req;
    // After a CPU grant, a waiting rx requester gets the next slot.
    assign w_pick_cpu = cpu_req && !(r_last_cpu && w_any_rx);
    assign w_start    = (r_state == c_ST_IDLE) && (cpu_req || w_any_rx);

    // Round-robin search starting at last_rx+1. The loop walks from the
    // farthest candidate to the nearest, so the nearest requester is the
    // last one assigned and therefore wins.
    always_comb begin
        w_rr_sum = '0;
        w_rr_idx = r_last_rx;
        for (int k = NumRx; k >= 1; k--) begin
            w_rr_sum = {1'b0, r_last_rx} + (c_IDX_W+1)'(k);
            if (w_rr_sum >= (c_IDX_W+1)'(NumRx)) begin
                w_rr_sum = w_rr_sum - (c_IDX_W+1)'(NumRx);
            end
            if (rx_req[w_rr_sum[c_IDX_W-1:0]]) begin
                w_rr_idx = w_rr_sum[c_IDX_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   w_state_nxt = w_start ? c_ST_ACCESS : c_ST_IDLE;
            c_ST_ACCESS: w_state_nxt = c_ST_RESP;
            c_ST_RESP:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Grant latching and registered table interface. The mem_* registers
    // double as the latched winner address/data; they are loaded on the
    // grant edge so the strobe is high for exactly the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cpu <= 1'b0;
            r_grant_we  <= 1'b0;
            r_grant_idx <= '0;
            r_last_rx   <= c_IDX_W'(NumRx - 1);
            r_last_cpu  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (w_start) begin
                r_mem_en <= 1'b1;
                if (w_pick_cpu) begin
                    r_grant_cpu <= 1'b1;
                    r_grant_we  <= cpu_we;
                    r_last_cpu  <= 1'b1;
                    r_mem_we    <= cpu_we;
                    r_mem_addr  <= cpu_addr;
                    r_mem_wdata <= cpu_wdata;
                end else begin
                    r_grant_cpu <= 1'b0;
                    r_grant_we  <= 1'b0;
                    r_grant_idx <= w_rr_idx;
                    r_last_rx   <= w_rr_idx;
                    r_last_cpu  <= 1'b0;
                    r_mem_addr  <= w_addr_arr[w_rr_idx];
                end
            end
        end
    end

    // Output decode: acks come only from state and grant registers; read
    // data is forced to zero outside the matching ack cycle.
    always_comb begin
        rx_ack    = '0;
        rx_rdata  = '0;
        cpu_ack   = 1'b0;
        cpu_rdata = '0;
        if (r_state == c_ST_RESP) begin
            if (r_grant_cpu) begin
                cpu_ack = 1'b1;
                if (!r_grant_we) begin
                    cpu_rdata = mem_rdata;
                end
            end else begin
                rx_ack[r_grant_idx] = 1'b1;
                rx_rdata            = mem_rdata;
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lut_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_lut_arbiter
// Purpose  : Self-checking bench for lut_arbiter. A transaction-level model
//            predicts every table access and every ack (cycle, port, data);
//            a monitor compares the DUT against the predicted queues.
// Revision : 1.0 - initial release
//==============================================================================
module tb_lut_arbiter;

    localparam int c_NUM_RX = 4;
    localparam int c_ASIZE  = 8;
    localparam int c_DSIZE  = 16;
    localparam int c_DEPTH  = 2 ** c_ASIZE;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [c_NUM_RX-1:0]       rx_req;
    logic [c_NUM_RX*c_ASIZE-1:0] rx_addr;
    logic [c_NUM_RX-1:0]       rx_ack;
    logic [c_DSIZE-1:0]        rx_rdata;
    logic                      cpu_req;
    logic                      cpu_we;
    logic [c_ASIZE-1:0]        cpu_addr;
    logic [c_DSIZE-1:0]        cpu_wdata;
    logic                      cpu_ack;
    logic [c_DSIZE-1:0]        cpu_rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [c_ASIZE-1:0]        mem_addr;
    logic [c_DSIZE-1:0]        mem_wdata;
    logic [c_DSIZE-1:0]        mem_rdata = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    lut_arbiter #(.NumRx(c_NUM_RX), .Asize(c_ASIZE), .Dsize(c_DSIZE)) dut (
        .clk(clk), .rst(rst),
        .rx_req(rx_req), .rx_addr(rx_addr), .rx_ack(rx_ack), .rx_rdata(rx_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // External table (the memory the arbiter drives)
    // ------------------------------------------------------------------
    logic [c_DSIZE-1:0] tbl     [c_DEPTH];
    logic [c_DSIZE-1:0] ref_tbl [c_DEPTH];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tbl[mem_addr] <= mem_wdata;
            else        mem_rdata     <= tbl[mem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Reference model: each grant occupies three cycles; the table access
    // happens in the grant cycle and the ack one cycle later.
    // ------------------------------------------------------------------
    typedef struct {
        int                 cyc;
        logic               cpu;
        int                 port;
        logic [c_DSIZE-1:0] data;
    } ack_t;

    typedef struct {
        int                 cyc;
        logic               we;
        logic [c_ASIZE-1:0] addr;
        logic [c_DSIZE-1:0] wdata;
    } mem_t;

    ack_t ackq[$];
    mem_t memq[$];

    int   cyc        = 0;
    int   next_free  = 0;
    int   m_last_rx  = c_NUM_RX - 1;
    bit   m_last_cpu = 0;
    int   m_sel;
    bit   m_found;
    ack_t m_a;
    mem_t m_m;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            next_free  = cyc + 1;
            m_last_rx  = c_NUM_RX - 1;
            m_last_cpu = 0;
            while (ackq.size() > 0 && ackq[$].cyc >= cyc) void'(ackq.pop_back());
        end else if (cyc >= next_free && (cpu_req || rx_req != '0)) begin
            m_m.cyc = cyc;
            m_a.cyc = cyc + 1;
            if (cpu_req && !(m_last_cpu && rx_req != '0)) begin
                m_m.we    = cpu_we;
                m_m.addr  = cpu_addr;
                m_m.wdata = cpu_wdata;
                m_a.cpu   = 1'b1;
                m_a.port  = 0;
                if (cpu_we) begin
                    ref_tbl[cpu_addr] = cpu_wdata;
                    m_a.data = '0;
                end else begin
                    m_a.data = ref_tbl[cpu_addr];
                end
                m_last_cpu = 1;
            end else begin
                m_found = 0;
                m_sel   = 0;
                for (int k = 1; k <= c_NUM_RX; k++) begin
                    if (!m_found && rx_req[(m_last_rx + k) % c_NUM_RX]) begin
                        m_found = 1;
                        m_sel   = (m_last_rx + k) % c_NUM_RX;
                    end
                end
                m_m.we    = 1'b0;
                m_m.addr  = rx_addr[m_sel*c_ASIZE +: c_ASIZE];
                m_m.wdata = '0;
                m_a.cpu   = 1'b0;
                m_a.port  = m_sel;
                m_a.data  = ref_tbl[m_m.addr];
                m_last_rx  = m_sel;
                m_last_cpu = 0;
            end
            memq.push_back(m_m);
            ackq.push_back(m_a);
            next_free = cyc + 3;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs with the predicted queues every cycle.
    // ------------------------------------------------------------------
    mem_t                mon_m;
    ack_t                mon_a;
    logic [c_NUM_RX-1:0] mon_ev;

    always @(negedge clk) begin
        if (memq.size() > 0 && memq[0].cyc == cyc) begin
            mon_m = memq.pop_front();
            check("mem_en", 32'(mem_en), 32'd1);
            check("mem_we", 32'(mem_we), 32'(mon_m.we));
            check("mem_addr", 32'(mem_addr), 32'(mon_m.addr));
            if (mon_m.we) check("mem_wdata", 32'(mem_wdata), 32'(mon_m.wdata));
        end else begin
            check("mem_en_idle", 32'(mem_en), 32'd0);
        end
        if (!mem_en) check("mem_we_without_en", 32'(mem_we), 32'd0);

        if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
            mon_a  = ackq.pop_front();
            mon_ev = mon_a.cpu ? '0 : (c_NUM_RX'(1) << mon_a.port);
            check("rx_ack", 32'(rx_ack), 32'(mon_ev));
            check("cpu_ack", 32'(cpu_ack), 32'(mon_a.cpu));
            check("rx_rdata", 32'(rx_rdata), mon_a.cpu ? 32'd0 : 32'(mon_a.data));
            check("cpu_rdata", 32'(cpu_rdata), mon_a.cpu ? 32'(mon_a.data) : 32'd0);
        end else begin
            check("rx_ack_idle", 32'(rx_ack), 32'd0);
            check("cpu_ack_idle", 32'(cpu_ack), 32'd0);
            check("rx_rdata_idle", 32'(rx_rdata), 32'd0);
            check("cpu_rdata_idle", 32'(cpu_rdata), 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int i, input logic r, input logic [c_ASIZE-1:0] a);
        rx_req[i] = r;
        rx_addr[i*c_ASIZE +: c_ASIZE] = a;
    endtask

    function automatic logic [c_ASIZE-1:0] raddr();
        if ($urandom_range(0, 7) == 0) return c_ASIZE'($urandom_range(0, c_DEPTH - 1));
        return c_ASIZE'($urandom_range(0, 15));
    endfunction

    task automatic new_cpu();
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = raddr();
        cpu_wdata = c_DSIZE'($urandom);
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        rx_req  = '0;
        cpu_req = 1'b0;
        step();
        step();
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rx_ack", 32'(rx_ack), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_rx_rdata", 32'(rx_rdata), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        rst = 1'b0;
    endtask

    int ack_port [$];
    int ack_cyc  [$];
    int n0;
    bit got;

    initial begin
        rst       = 1'b1;
        rx_req    = '0;
        rx_addr   = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int a = 0; a < c_DEPTH; a++) begin
            tbl[a]     = c_DSIZE'(a * 16'h0101) ^ 16'h5A5A;
            ref_tbl[a] = c_DSIZE'(a * 16'h0101) ^ 16'h5A5A;
        end
        tbl[8'h15]     = 16'hABCD;
        ref_tbl[8'h15] = 16'hABCD;

        reset_dut();

        // Single rx read: strobe in the grant cycle, ack one cycle later.
        set_rx(2, 1'b1, 8'h15);
        step();
        check("d1_mem_en", 32'(mem_en), 32'd1);
        check("d1_mem_addr", 32'(mem_addr), 32'h15);
        step();
        check("d1_rx_ack", 32'(rx_ack), 32'b0100);
        check("d1_rx_rdata", 32'(rx_rdata), 32'hABCD);
        set_rx(2, 1'b0, 8'h00);
        step();

        // All rx ports requesting from reset: round-robin order 0,1,2,3,0.
        rst = 1'b1;
        for (int i = 0; i < c_NUM_RX; i++) set_rx(i, 1'b1, c_ASIZE'(i + 1));
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            for (int i = 0; i < c_NUM_RX; i++) begin
                if (rx_ack[i]) begin
                    ack_port.push_back(i);
                    ack_cyc.push_back(c);
                end
            end
        end
        check("rr_ack_count", 32'(ack_port.size()), 32'd5);
        for (int k = 0; k < 5 && k < ack_port.size(); k++) begin
            check("rr_order", 32'(ack_port[k]), 32'(k % c_NUM_RX));
            if (k > 0) check("rr_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
        end
        reset_dut();

        // CPU and rx port 1 together; CPU stays requesting for a second write.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h07;
        cpu_wdata = 16'h1234;
        set_rx(1, 1'b1, 8'h40);
        step();
        check("d3_cpu_we", 32'(mem_we), 32'd1);
        check("d3_cpu_addr", 32'(mem_addr), 32'h07);
        check("d3_cpu_wdata", 32'(mem_wdata), 32'h1234);
        step();
        check("d3_cpu_ack", 32'(cpu_ack), 32'd1);
        check("d3_cpu_rdata_w", 32'(cpu_rdata), 32'd0);
        cpu_addr  = 8'h08;
        cpu_wdata = 16'h5678;
        step();
        step();
        check("d3_rx1_en", 32'(mem_en), 32'd1);
        check("d3_rx1_we", 32'(mem_we), 32'd0);
        check("d3_rx1_addr", 32'(mem_addr), 32'h40);
        step();
        check("d3_rx1_ack", 32'(rx_ack), 32'b0010);
        set_rx(1, 1'b0, 8'h00);
        step();
        step();
        check("d3_cpu2_we", 32'(mem_we), 32'd1);
        check("d3_cpu2_addr", 32'(mem_addr), 32'h08);
        step();
        check("d3_cpu2_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;

        // Read back the CPU write through rx port 3.
        set_rx(3, 1'b1, 8'h07);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (rx_ack[3]) got = 1;
        end
        check("d4_rx3_ack", 32'(rx_ack), 32'b1000);
        check("d4_rx3_rdata", 32'(rx_rdata), 32'h1234);
        set_rx(3, 1'b0, 8'h00);
        reset_dut();

        // Reset during ACCESS aborts port 1; it is served again first.
        set_rx(1, 1'b1, 8'h21);
        set_rx(2, 1'b1, 8'h22);
        step();
        check("d5_first_addr", 32'(mem_addr), 32'h21);
        rst = 1'b1;
        step();
        check("d5_en_after_rst", 32'(mem_en), 32'd0);
        check("d5_no_ack", 32'(rx_ack), 32'd0);
        rst = 1'b0;
        step();
        check("d5_regrant_en", 32'(mem_en), 32'd1);
        check("d5_regrant_addr", 32'(mem_addr), 32'h21);
        step();
        check("d5_ack_p1", 32'(rx_ack), 32'b0010);
        reset_dut();

        // Port 0 drops its request during ACCESS: single ack, no retry.
        set_rx(0, 1'b1, 8'h30);
        step();
        check("d6_en", 32'(mem_en), 32'd1);
        rx_req[0] = 1'b0;
        step();
        check("d6_ack", 32'(rx_ack), 32'b0001);
        n0 = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (rx_ack[0] || mem_en) n0++;
        end
        check("d6_no_retry", 32'(n0), 32'd0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 149) == 0) rst = 1'b1;
            for (int i = 0; i < c_NUM_RX; i++) begin
                if (rx_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) set_rx(i, 1'b1, raddr());
                    else                           set_rx(i, 1'b0, raddr());
                end else if (!rx_req[i] && $urandom_range(0, 3) == 0) begin
                    set_rx(i, 1'b1, raddr());
                end
            end
            if (cpu_ack) begin
                if ($urandom_range(0, 1) == 1) new_cpu();
                else cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 4) == 0) begin
                new_cpu();
            end
        end

        reset_dut();
        step();
        check("ackq_drained", 32'(ackq.size()), 32'd0);
        check("memq_drained", 32'(memq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lut_arbiter.md
LUT_ARBITER -- requirements
Module: lut_arbiter

Interface
REQ-001 Parameter NumRx, default 4: number of receive-port lookup requesters (2..16).
REQ-002 Parameter Asize, default 8: lookup-table address width.
REQ-003 Parameter Dsize, default 16: lookup-table entry width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx_req  input  NumRx  per-port read request; bit i = port i.
REQ-007 rx_addr  input  NumRx*Asize  packed read addresses; port i at [i*Asize +: Asize].
REQ-008 rx_ack  output  NumRx  one-cycle completion pulse per port.
REQ-009 rx_rdata  output  Dsize  read data, shared by all ports, valid only while some rx_ack bit is 1.
REQ-010 cpu_req  input  1  configuration-port access request.
REQ-011 cpu_we  input  1  1 = write, 0 = read; qualified by cpu_req.
REQ-012 cpu_addr  input  Asize  configuration address.
REQ-013 cpu_wdata  input  Dsize  configuration write data.
REQ-014 cpu_ack  output  1  one-cycle completion pulse.
REQ-015 cpu_rdata  output  Dsize  read data, valid only while cpu_ack is 1.
REQ-016 mem_en  output  1  single-port table access strobe.
REQ-017 mem_we  output  1  table write enable, valid with mem_en.
REQ-018 mem_addr  output  Asize  table address.
REQ-019 mem_wdata  output  Dsize  table write data.
REQ-020 mem_rdata  input  Dsize  table read data, valid the cycle after a mem_en read cycle.

Function
REQ-021 Requesters SHALL hold req, addr, we and wdata stable from assertion until the ack cycle; req may stay high after ack to request again.
REQ-022 FSM states: IDLE, ACCESS, RESP; one table access in flight at a time.
REQ-023 IDLE: no request pending -> stay IDLE; else latch the winner (grant, addr, we, wdata) -> ACCESS.
REQ-024 ACCESS lasts exactly one cycle: mem_en=1, mem_addr/mem_we/mem_wdata from latched values -> RESP.
REQ-025 RESP lasts exactly one cycle: ack of the granted requester = 1; its rdata = mem_rdata for a read, 0 for a CPU write -> IDLE.
REQ-026 Latency: request first sampled high at edge N -> mem_en high in cycle N..N+1 -> ack high in cycle N+1..N+2; minimum 3-cycle spacing between grants.
REQ-027 Priority: CPU over rx, except when the previous grant went to CPU and any rx_req is high; that rx requester wins.
REQ-028 Rx selection is round-robin: search starts at last_rx+1 mod NumRx; last_rx updates only on an rx grant.
REQ-029 mem_en, mem_we, mem_addr and mem_wdata SHALL be registered; rx_ack and cpu_ack SHALL be decoded from state/grant registers only.
REQ-030 rx_rdata and cpu_rdata SHALL be 0 in every cycle where the corresponding ack is 0.
REQ-031 mem_we SHALL be 0 whenever mem_en is 0; mem_addr/mem_wdata hold their last values.
REQ-032 A requester dropping req before its ack: the access still completes and ack still pulses; no retry is issued.
REQ-033 Rx requests are always reads; mem_we=1 only for CPU writes.
REQ-034 Address values use the full Asize range; no wrap or range checks.

Reset
REQ-035 rst=1 at an edge -> state IDLE, last_rx = NumRx-1 (port 0 served first), last-grant-was-CPU flag = 0; all outputs 0 in the following cycle.
REQ-036 rst asserted in ACCESS or RESP aborts the access: no ack is issued for it; the requester must re-request.
REQ-037 Requests sampled while rst=1 are ignored.

Verification
REQ-038 Table[0x15]=0xABCD; rx_req[2] rises before edge 1 with addr 0x15 -> mem_en=1, addr 0x15 in cycle 1; rx_ack=0b0100 with rx_rdata=0xABCD in cycle 2.
REQ-039 rx_req=0b1111 held from reset -> acks in order port 0,1,2,3,0, three cycles apart; rx_rdata=0 between acks.
REQ-040 cpu_req (write 0x1234 to 0x07) and rx_req[1] rise at the same edge; cpu_req held for a second write -> CPU write, then port 1 read, then second CPU write.
REQ-041 CPU write 0x1234 to 0x07, then rx_req[3] read of 0x07 -> rx_ack[3] with rx_rdata=0x1234; during the CPU ack cycle cpu_rdata=0.
REQ-042 rx_req=0b0110; rst pulsed one cycle while in ACCESS for port 1 -> no ack for port 1; mem_en=0 the cycle after reset; next grant goes to port 1 (search from port 0).
REQ-043 rx_req[0] dropped during ACCESS -> rx_ack[0] still pulses once; no further grant to port 0.
